// File: rtl/clock_divider_if.sv
// Output bundle of the even-ratio clock divider: count enable in, divided clock and
// rising-edge strobe out.
interface clock_divider_if;
  logic en;
  logic clk_out;
  logic rise_tick;

  modport master (
    output en,
    input  clk_out,
    input  rise_tick
  );

  modport slave (
    input  en,
    output clk_out,
    output rise_tick
  );
endinterface

// File: rtl/clock_divider.sv
// Even-ratio clock divider: 50 % duty clk_out at clk_i / (2*DIV_2N), plus a one-cycle
// strobe marking each clk_out rising edge. All outputs are direct flop outputs.
module clock_divider #(
  parameter int unsigned DIV_2N = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  clock_divider_if.slave div_io
);

  localparam int unsigned CNT_W = (DIV_2N > 1) ? $clog2(DIV_2N) : 1;
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DIV_2N - 1);

  generate
    if (DIV_2N < 1 || DIV_2N > 65535) begin : g_bad_div
      $error("clock_divider: DIV_2N must be in 1..65535");
    end
  endgenerate

  // Declaration initial values give a clean waveform even with reset tied low.
  logic [CNT_W-1:0] cnt_q = '0;
  logic             clk_out_q = 1'b0;
  logic             rise_tick_q = 1'b0;
  logic [CNT_W-1:0] cnt_d;
  logic             clk_out_d;
  logic             rise_tick_d;

  always_comb begin
    cnt_d       = cnt_q;
    clk_out_d   = clk_out_q;
    rise_tick_d = 1'b0;
    if (div_io.en) begin
      if (cnt_q == CntMax) begin
        cnt_d       = '0;
        clk_out_d   = ~clk_out_q;
        rise_tick_d = ~clk_out_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      clk_out_q   <= 1'b0;
      rise_tick_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      clk_out_q   <= clk_out_d;
      rise_tick_q <= rise_tick_d;
    end
  end

  assign div_io.clk_out   = clk_out_q;
  assign div_io.rise_tick = rise_tick_q;

endmodule

// File: tb/tb_clock_divider.sv
// Directed bench for clock_divider: five instances (DIV_2N = 1, 2, 3, 4, 5) on one clock.
module tb_clock_divider;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk_i = ~clk_i;

  clock_divider_if if1 ();
  clock_divider_if if2 ();
  clock_divider_if if3 ();
  clock_divider_if if4 ();
  clock_divider_if if5 ();

  clock_divider #(.DIV_2N(1)) u_d1 (.clk_i(clk_i), .rst_i(rst_i), .div_io(if1));
  clock_divider #(.DIV_2N(2)) u_d2 (.clk_i(clk_i), .rst_i(rst_i), .div_io(if2));
  clock_divider #(.DIV_2N(3)) u_d3 (.clk_i(clk_i), .rst_i(rst_i), .div_io(if3));
  clock_divider #(.DIV_2N(4)) u_d4 (.clk_i(clk_i), .rst_i(rst_i), .div_io(if4));
  clock_divider #(.DIV_2N(5)) u_d5 (.clk_i(clk_i), .rst_i(rst_i), .div_io(if5));

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Reset never asserted: start from initial values, then /2 and /4 waveforms.
  task automatic test_no_reset();
    logic e1, t1, e2, t2;
    #1;
    checks++;
    if ({if1.clk_out, if2.clk_out, if3.clk_out, if4.clk_out, if5.clk_out} !== 5'b0) begin
      errors++;
      $display("FAIL init_clk_out: got %b want 00000",
               {if1.clk_out, if2.clk_out, if3.clk_out, if4.clk_out, if5.clk_out});
    end
    checks++;
    if ({if1.rise_tick, if2.rise_tick} !== 2'b0) begin
      errors++;
      $display("FAIL init_rise_tick: got %b want 00", {if1.rise_tick, if2.rise_tick});
    end
    for (int k = 1; k <= 12; k++) begin
      step();
      e1 = k[0];
      t1 = k[0];
      e2 = ((k / 2) % 2) == 1;
      t2 = (k % 4) == 2;
      checks++;
      if (if1.clk_out !== e1 || if1.rise_tick !== t1) begin
        errors++;
        $display("FAIL noreset_d1 edge %0d: got out=%b tick=%b want out=%b tick=%b",
                 k, if1.clk_out, if1.rise_tick, e1, t1);
      end
      checks++;
      if (if2.clk_out !== e2 || if2.rise_tick !== t2) begin
        errors++;
        $display("FAIL noreset_d2 edge %0d: got out=%b tick=%b want out=%b tick=%b",
                 k, if2.clk_out, if2.rise_tick, e2, t2);
      end
    end
  endtask

  // Asynchronous reset away from a clock edge clears outputs immediately.
  task automatic test_reset();
    step();
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if ({if1.clk_out, if1.rise_tick, if2.clk_out, if2.rise_tick} !== 4'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0000",
               {if1.clk_out, if1.rise_tick, if2.clk_out, if2.rise_tick});
    end
    checks++;
    if (u_d2.cnt_q !== 1'b0) begin
      errors++;
      $display("FAIL reset_cnt_d2: got %0d want 0", u_d2.cnt_q);
    end
    #2 rst_i = 1'b0;
  endtask

  // After reset release: /2 rises on odd edges, /4 rises on edges 2, 6, 10, 14.
  task automatic test_div2_alongside();
    logic e1, t1, e2, t2;
    for (int k = 1; k <= 16; k++) begin
      step();
      e1 = k[0];
      t1 = k[0];
      e2 = ((k / 2) % 2) == 1;
      t2 = (k % 4) == 2;
      checks++;
      if (if1.clk_out !== e1 || if1.rise_tick !== t1) begin
        errors++;
        $display("FAIL div1 edge %0d: got out=%b tick=%b want out=%b tick=%b",
                 k, if1.clk_out, if1.rise_tick, e1, t1);
      end
      checks++;
      if (if2.clk_out !== e2 || if2.rise_tick !== t2) begin
        errors++;
        $display("FAIL div2 edge %0d: got out=%b tick=%b want out=%b tick=%b",
                 k, if2.clk_out, if2.rise_tick, e2, t2);
      end
    end
  endtask

  // /10 over 100 cycles (1000 ns): ten rises, ten ticks, each tick on a rise.
  task automatic test_div5();
    int   rises = 0;
    int   ticks = 0;
    int   wave_err = 0;
    logic prev = 1'b0;
    logic e;
    if5.en = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      step();
      e = ((k / 5) % 2) == 1;
      if (if5.clk_out !== e) wave_err++;
      if (if5.rise_tick !== (if5.clk_out & ~prev)) wave_err++;
      if (if5.clk_out === 1'b1 && prev === 1'b0) rises++;
      if (if5.rise_tick === 1'b1) ticks++;
      prev = if5.clk_out;
    end
    checks++;
    if (wave_err != 0) begin
      errors++;
      $display("FAIL div5_wave: got %0d bad edges want 0", wave_err);
    end
    checks++;
    if (rises != 10) begin
      errors++;
      $display("FAIL div5_rises: got %0d want 10", rises);
    end
    checks++;
    if (ticks != 10) begin
      errors++;
      $display("FAIL div5_ticks: got %0d want 10", ticks);
    end
  endtask

  // /6 instance reset while high with cnt=1; first rise after release on edge 3.
  task automatic test_async_reset_mid();
    logic e, t;
    if3.en = 1'b1;
    for (int k = 1; k <= 4; k++) step();
    checks++;
    if (if3.clk_out !== 1'b1 || u_d3.cnt_q !== 2'd1) begin
      errors++;
      $display("FAIL d3_pre_reset: got out=%b cnt=%0d want out=1 cnt=1",
               if3.clk_out, u_d3.cnt_q);
    end
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if (if3.clk_out !== 1'b0 || if3.rise_tick !== 1'b0 || u_d3.cnt_q !== 2'd0) begin
      errors++;
      $display("FAIL d3_async_reset: got out=%b tick=%b cnt=%0d want 0 0 0",
               if3.clk_out, if3.rise_tick, u_d3.cnt_q);
    end
    #2 rst_i = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      e = (k == 3);
      t = (k == 3);
      checks++;
      if (if3.clk_out !== e || if3.rise_tick !== t) begin
        errors++;
        $display("FAIL d3_after_release edge %0d: got out=%b tick=%b want out=%b tick=%b",
                 k, if3.clk_out, if3.rise_tick, e, t);
      end
    end
  endtask

  // /8 instance: en low for 7 cycles at cnt=2 freezes; toggle lands 2 edges after resume.
  task automatic test_enable_freeze();
    logic e, t;
    if4.en = 1'b1;
    step();
    step();
    checks++;
    if (u_d4.cnt_q !== 2'd2 || if4.clk_out !== 1'b0) begin
      errors++;
      $display("FAIL d4_pre_freeze: got cnt=%0d out=%b want cnt=2 out=0",
               u_d4.cnt_q, if4.clk_out);
    end
    if4.en = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      checks++;
      if (u_d4.cnt_q !== 2'd2 || if4.clk_out !== 1'b0 || if4.rise_tick !== 1'b0) begin
        errors++;
        $display("FAIL d4_frozen cycle %0d: got cnt=%0d out=%b tick=%b want 2 0 0",
                 k, u_d4.cnt_q, if4.clk_out, if4.rise_tick);
      end
    end
    if4.en = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      e = (k >= 2 && k <= 5);
      t = (k == 2);
      checks++;
      if (if4.clk_out !== e || if4.rise_tick !== t) begin
        errors++;
        $display("FAIL d4_resume edge %0d: got out=%b tick=%b want out=%b tick=%b",
                 k, if4.clk_out, if4.rise_tick, e, t);
      end
    end
  endtask

  initial begin
    if1.en = 1'b1;
    if2.en = 1'b1;
    if3.en = 1'b0;
    if4.en = 1'b0;
    if5.en = 1'b0;
    test_no_reset();
    test_reset();
    test_div2_alongside();
    test_div5();
    test_async_reset_mid();
    test_enable_freeze();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
